// File: rtl/sigmoid_arb_pkg.sv
// Shared constants and tag-width helpers for the sigmoid share arbiter.
package sigmoid_arb_pkg;

  localparam logic [31:0] FLOAT_ONE  = 32'h3F800000;
  localparam logic [31:0] FLOAT_HALF = 32'h3F000000;

  localparam int N_REQ_DEF = 4;

  // Owner tag width for n requesters; a single bit is kept even for n <= 2.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = id_width(N_REQ_DEF);

  typedef logic [ID_W-1:0] tag_t;

endpackage

// File: rtl/sigmoid_tag_fifo.sv
// In-order owner-tag FIFO: first-word-fall-through read, wrap-around pointers,
// push and pop in the same cycle accepted at any occupancy (including full).
module sigmoid_tag_fifo
  import sigmoid_arb_pkg::*;
#(
  parameter int WIDTH = ID_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // Pop only real entries; a push into a full FIFO is taken only alongside a pop.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin sharing of one pipelined sigmoid unit among N_REQ requesters.
// Owner tags travel through an in-order FIFO and steer each result back as a
// one-cycle rsp_valid pulse. Optional macro SIGMOID_ARB_PERF_EN adds
// saturating issue / stall performance counters.
module sigmoid_share_arbiter
  import sigmoid_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 16,
  parameter int DATA_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      unit_valid,
  output logic [DATA_W-1:0]         unit_din,
  input  logic                      unit_ready,
  input  logic                      unit_done,
  input  logic [DATA_W-1:0]         unit_dout,
  output logic                      busy,
  output logic                      err_orphan
`ifdef SIGMOID_ARB_PERF_EN
  ,
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_stall_full,
  output logic [31:0]               perf_stall_unit
`endif
);

  localparam int TAG_W = id_width(N_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [TAG_W-1:0]  rr_q, rr_d, gnt, tag_head;
  logic              found, issue, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  inflight;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  int                idx;

  // Round-robin search: first valid requester at or after rr_q, wrapping.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = TAG_W'(idx);
      end
    end
  end

  // Issue handshake toward the unit; the pointer only moves on a real issue.
  always_comb begin
    issue      = found & unit_ready & ~fifo_full;
    req_ready  = issue ? (N_REQ'(1) << gnt) : '0;
    unit_valid = issue;
    unit_din   = issue ? req_data[int'(gnt)*DATA_W +: DATA_W] : '0;
    rr_d       = rr_q;
    if (issue) rr_d = (gnt == TAG_W'(N_REQ-1)) ? '0 : gnt + TAG_W'(1);
  end

  // Completion steering: pop the owner tag, or flag an orphan result.
  always_comb begin
    pop         = unit_done & ~fifo_empty;
    rsp_valid_d = pop ? (N_REQ'(1) << tag_head) : '0;
    rsp_data_d  = pop ? unit_dout : rsp_data_q;
    err_d       = err_q | (unit_done & fifo_empty);
  end

  sigmoid_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .din_i   (gnt),
    .pop_i   (pop),
    .dout_o  (tag_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (inflight)
  );

  // Pointer, response and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_q;
  assign busy       = (inflight != '0);

`ifdef SIGMOID_ARB_PERF_EN
  logic [31:0] iss_q, sfull_q, sunit_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_q   <= '0;
      sfull_q <= '0;
      sunit_q <= '0;
    end else begin
      iss_q   <= sat_inc(iss_q, issue);
      sfull_q <= sat_inc(sfull_q, found & unit_ready & fifo_full);
      sunit_q <= sat_inc(sunit_q, found & ~unit_ready);
    end
  end

  assign perf_issued     = iss_q;
  assign perf_stall_full = sfull_q;
  assign perf_stall_unit = sunit_q;
`endif

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Randomized bench with a queue-based reference model of the arbiter and a
// fixed-latency, in-order sigmoid unit model.
module tb_sigmoid_share_arbiter;
  import sigmoid_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXI = 16;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, unit_din, unit_dout;
  logic            unit_valid, unit_ready, unit_done, busy, err_orphan;
`ifdef SIGMOID_ARB_PERF_EN
  logic [31:0]     perf_issued, perf_stall_full, perf_stall_unit;
`endif

  sigmoid_share_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MAXI), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .unit_valid (unit_valid),
    .unit_din   (unit_din),
    .unit_ready (unit_ready),
    .unit_done  (unit_done),
    .unit_dout  (unit_dout),
    .busy       (busy),
    .err_orphan (err_orphan)
`ifdef SIGMOID_ARB_PERF_EN
    ,
    .perf_issued     (perf_issued),
    .perf_stall_full (perf_stall_full),
    .perf_stall_unit (perf_stall_unit)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            rr;
  int            tagq[$];
  logic [DW-1:0] uq_d[$];
  int            uq_t[$];
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rd;
  logic          exp_err;
  int            p_iss, p_sf, p_su;
  int            cyc = 0;
  int            L = 5;

  // Requester / unit stimulus controls
  logic          pend_v[N];
  logic [DW-1:0] pend_d[N];
  logic [N-1:0]  active_mask;
  int            rate;
  int            ready_mode;
  logic          force_orphan;

  // Decisions of the current cycle, committed at the next edge
  logic          c_issue, c_pop, c_done, c_from_uq, c_sf, c_su;
  int            c_g;
  logic [DW-1:0] c_dout;

  int dut_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Stand-in for the sigmoid unit: exact at 0, an arbitrary bijection elsewhere.
  function automatic logic [DW-1:0] ufn(input logic [DW-1:0] x);
    return (x == '0) ? FLOAT_HALF : ((x ^ FLOAT_ONE) + 32'd1);
  endfunction

  task automatic clear_model();
    rr = 0;
    tagq.delete();
    uq_d.delete();
    uq_t.delete();
    exp_rv = '0; exp_rd = '0; exp_err = 1'b0;
    p_iss = 0; p_sf = 0; p_su = 0;
    c_issue = 0; c_pop = 0; c_done = 0; c_from_uq = 0; c_sf = 0; c_su = 0;
    c_g = 0; c_dout = '0;
    for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_d[i] = '0; end
  endtask

  task automatic drive_idle();
    req_valid = '0; req_data = '0; unit_ready = 1'b0;
    unit_done = 1'b0; unit_dout = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_unit_valid"}, unit_valid, 0);
    chk({tag, "_unit_din"}, unit_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_orphan, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    #1 chk_all_zero("rst_now");
    @(posedge clk); #1;
    chk_all_zero("rst_next");
    rst = 1'b0;
    clear_model();
  endtask

  // One clock: commit the last cycle's decisions, drive new inputs, compare.
  task automatic cycle();
    int i, o;
    logic [N-1:0] e_rr;
    @(posedge clk); #1;
    if (c_pop) begin
      o = tagq.pop_front();
      exp_rv = '0; exp_rv[o] = 1'b1;
      exp_rd = c_dout;
    end else begin
      exp_rv = '0;
      if (c_done) exp_err = 1'b1;
    end
    if (c_from_uq) begin void'(uq_d.pop_front()); void'(uq_t.pop_front()); end
    if (c_issue) begin
      tagq.push_back(c_g);
      rr = (c_g + 1) % N;
      uq_d.push_back(ufn(pend_d[c_g]));
      uq_t.push_back(cyc + L);
      pend_v[c_g] = 1'b0;
      p_iss++;
    end
    if (c_sf) p_sf++;
    if (c_su) p_su++;
    cyc++;

    for (int k = 0; k < N; k++) begin
      if (!pend_v[k] && active_mask[k] && ($urandom_range(99) < rate)) begin
        pend_v[k] = 1'b1;
        pend_d[k] = ($urandom_range(3) == 0) ? '0 : $urandom;
      end
      req_valid[k] = pend_v[k];
      req_data[k*DW +: DW] = pend_d[k];
    end
    case (ready_mode)
      0: unit_ready = 1'b1;
      1: unit_ready = $urandom_range(1) != 0;
      default: unit_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    endcase
    c_from_uq = (uq_t.size() > 0) && (uq_t[0] == cyc);
    c_done    = c_from_uq || force_orphan;
    c_dout    = c_from_uq ? uq_d[0] : $urandom;
    unit_done = c_done;
    unit_dout = c_dout;

    c_g = -1;
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
      if (c_g < 0 && pend_v[i]) c_g = i;
    end
    c_issue = (c_g >= 0) && unit_ready && (tagq.size() < MAXI);
    c_sf    = (c_g >= 0) && unit_ready && (tagq.size() == MAXI);
    c_su    = (c_g >= 0) && !unit_ready;
    c_pop   = c_done && (tagq.size() > 0);
    if (c_g < 0) c_g = 0;

    #1;
    e_rr = c_issue ? (N'(1) << c_g) : '0;
    chk("req_ready", req_ready, e_rr);
    chk("unit_valid", unit_valid, c_issue);
    chk("unit_din", unit_din, c_issue ? pend_d[c_g] : '0);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", rsp_data, exp_rd);
    chk("busy", busy, tagq.size() != 0);
    chk("err_orphan", err_orphan, exp_err);
`ifdef SIGMOID_ARB_PERF_EN
    chk("perf_issued", perf_issued, p_iss);
    chk("perf_stall_full", perf_stall_full, p_sf);
    chk("perf_stall_unit", perf_stall_unit, p_su);
`endif
    if (unit_valid)
      for (int k = 0; k < N; k++) if (req_ready[k]) dut_log.push_back(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1;
    drive_idle();
    clear_model();
    active_mask = '0; rate = 0; ready_mode = 0; force_orphan = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    do_reset();

    // Single request from requester 2 with operand 0.
    L = 5;
    pend_v[2] = 1'b1; pend_d[2] = '0;
    cycle();
    t0 = cyc;
    chk("single_ready", req_ready, 4'b0100);
    repeat (5) cycle();
    chk("single_early", rsp_valid, 4'b0000);
    cycle();
    chk("single_lat", cyc - t0, 6);
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_data", rsp_data, 32'h3F000000);

    // Fairness: all requesters streaming from a fresh pointer.
    do_reset();
    active_mask = 4'b1111; rate = 100; dut_log.delete();
    repeat (9) cycle();
    for (int k = 0; k < 8; k++)
      chk("fair_grant", (k < dut_log.size()) ? dut_log[k] : -1, k % 4);

    // Full: long unit latency, one streaming requester.
    do_reset();
    L = 40; active_mask = 4'b0001; rate = 100; dut_log.delete();
    repeat (40) cycle();
    chk("full_issue_count", dut_log.size(), 16);
    chk("full_blocked", req_ready, 4'b0000);
    chk("full_busy", busy, 1);
    repeat (30) cycle();
    active_mask = '0; rate = 0;
    repeat (70) cycle();

    // Unit backpressure with a 1,0,0,1 ready pattern.
    L = 3; active_mask = 4'b1111; rate = 70; ready_mode = 2;
    repeat (200) cycle();
    active_mask = '0; ready_mode = 0;
    repeat (30) cycle();

    // Fully random traffic and ready, random latency.
    L = $urandom_range(8, 1); active_mask = 4'b1111; rate = 50; ready_mode = 1;
    repeat (300) cycle();
    active_mask = '0; ready_mode = 0;
    repeat (40) cycle();

    // Orphan completion with nothing in flight.
    force_orphan = 1'b1;
    cycle();
    force_orphan = 1'b0;
    cycle();
    chk("orphan_err", err_orphan, 1);
    chk("orphan_no_rsp", rsp_valid, 4'b0000);

    // Reset with work in flight, then a stale completion.
    L = 20; active_mask = 4'b0001; rate = 100;
    repeat (4) cycle();
    chk("pre_reset_busy", busy, 1);
    active_mask = '0; rate = 0;
    do_reset();
    force_orphan = 1'b1;
    cycle();
    force_orphan = 1'b0;
    cycle();
    chk("stale_done_err", err_orphan, 1);
    chk("stale_done_no_rsp", rsp_valid, 4'b0000);

`ifdef SIGMOID_ARB_PERF_EN
    // Perf: 16 issues then 3 full-stall cycles.
    do_reset();
    L = 40; active_mask = 4'b0001; rate = 100;
    repeat (20) cycle();
    chk("perf_lit_issued", perf_issued, 16);
    chk("perf_lit_full", perf_stall_full, 3);
    chk("perf_lit_unit", perf_stall_unit, 0);
    active_mask = '0; rate = 0;
    repeat (70) cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
